// File: rtl/adc_ramp_ctrl.sv
// adc_ramp_ctrl: single-slope ADC ramp sequencer; define ADC_CONT_EN for continuous conversion mode
module adc_ramp_ctrl #(
  parameter int SETTLE_CYC = 4
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       start,
  input  logic       abort,
  input  logic       comp_in,
  input  logic       roll,
  input  logic       ready,
  output logic       cnt_rst_n,
  output logic [6:0] data,
  output logic       ovr,
  output logic       valid,
  output logic       busy
);
  typedef enum logic [1:0] {IDLE, SETTLE, RAMP, HOLD} state_t;
`ifdef ADC_CONT_EN
  localparam state_t AFTER_XFER = SETTLE;
`else
  localparam state_t AFTER_XFER = IDLE;
`endif
  localparam logic [3:0] SETTLE_LD = 4'(SETTLE_CYC - 1);
  state_t state, state_nx;
  logic c1, comp_s, hit, over;
  logic [3:0] settle_cnt;
  logic [6:0] code;
  assign hit = state == RAMP && comp_s;
  assign over = state == RAMP && !comp_s && (roll || code == 7'd127);
  assign cnt_rst_n = state == RAMP;
  assign valid = state == HOLD;
  assign busy = state != IDLE;
  // two-flop synchronizer for the asynchronous comparator
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) {comp_s, c1} <= '0;
    else {comp_s, c1} <= {c1, comp_in};
  // next-state logic; abort overrides every other condition
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    state_nx = start ? SETTLE : IDLE;
      SETTLE:  state_nx = settle_cnt == 4'd0 ? RAMP : SETTLE;
      RAMP:    state_nx = (hit || over) ? HOLD : RAMP;
      HOLD:    state_nx = ready ? AFTER_XFER : HOLD;
      default: state_nx = IDLE;
    endcase
    if (abort) state_nx = IDLE;
  end
  // state, settle countdown and ramp code tracking
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state      <= IDLE;
      settle_cnt <= '0;
      code       <= '0;
    end else begin
      state      <= state_nx;
      settle_cnt <= (state_nx == SETTLE && state != SETTLE) ? SETTLE_LD :
                    (state == SETTLE && settle_cnt != 4'd0) ? settle_cnt - 4'd1 : settle_cnt;
      code       <= (state == RAMP && state_nx == RAMP) ? code + 7'd1 : 7'd0;
    end
  // result capture; an abort in the same cycle discards the trip
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      data <= '0;
      ovr  <= 1'b0;
    end else if (!abort && hit) begin
      data <= code;
      ovr  <= 1'b0;
    end else if (!abort && over) begin
      data <= 7'd127;
      ovr  <= 1'b1;
    end
endmodule

// File: tb/tb_adc_ramp_ctrl.sv
// tb_adc_ramp_ctrl: directed bench with an external ramp counter model and threshold-driven comparator
module tb_adc_ramp_ctrl;
  logic clk = 0, reset_n = 0, start = 0, abort = 0, ready = 0;
  logic comp_in, roll, cnt_rst_n, ovr, valid, busy;
  logic [6:0] data;
  logic [6:0] ext = '0;
  logic comp_en = 0;
  int thr = 0;
  int tests = 0, fails = 0;

  adc_ramp_ctrl #(.SETTLE_CYC(4)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .abort(abort), .comp_in(comp_in),
    .roll(roll), .ready(ready), .cnt_rst_n(cnt_rst_n), .data(data), .ovr(ovr),
    .valid(valid), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) ext <= cnt_rst_n ? ext + 7'd1 : 7'd0;
  assign roll = ext == 7'd127;
  // comparator leads the wanted code by the two synchronizer stages
  assign comp_in = comp_en && int'(ext) >= thr - 2;

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  task automatic launch(input int ign_at, output int lat, output int ramp_at);
    lat = -1;
    ramp_at = -1;
    start = 1;
    @(negedge clk);
    start = 0;
    for (int i = 1; i <= 400; i++) begin
      if (cnt_rst_n && ramp_at < 0) ramp_at = i;
      if (valid) begin lat = i; break; end
      start = (i == ign_at);
      @(negedge clk);
    end
    start = 0;
  endtask

  task automatic xfer;
    ready = 1;
    @(negedge clk);
    ready = 0;
  endtask

  task automatic test_reset;
    #1;
    tests++; if ({busy, valid, cnt_rst_n, ovr} !== 4'b0) begin fails++; $display("FAIL reset_flags got %b exp 0000", {busy, valid, cnt_rst_n, ovr}); end
    tests++; if (data !== 7'd0) begin fails++; $display("FAIL reset_data got %0d exp 0", data); end
    repeat (2) @(negedge clk);
    reset_n = 1;
    @(negedge clk);
  endtask

  task automatic test_single;
    int lat, ra;
    thr = 37; comp_en = 1;
    launch(0, lat, ra);
    tests++; if (ra !== 5) begin fails++; $display("FAIL single_settle got %0d exp 5", ra); end
    tests++; if (lat !== 43) begin fails++; $display("FAIL single_latency got %0d exp 43", lat); end
    tests++; if (data !== 7'd37 || ovr !== 1'b0) begin fails++; $display("FAIL single_result got %0d/%b exp 37/0", data, ovr); end
    repeat (3) @(negedge clk);
    tests++; if (valid !== 1'b1 || busy !== 1'b1) begin fails++; $display("FAIL single_hold got %b%b exp 11", valid, busy); end
    xfer();
    tests++; if (valid !== 1'b0 || busy !== 1'b0) begin fails++; $display("FAIL single_done got %b%b exp 00", valid, busy); end
  endtask

  task automatic test_overrange;
    int lat, ra;
    comp_en = 0;
    launch(30, lat, ra);
    tests++; if (lat !== 133) begin fails++; $display("FAIL ovr_latency got %0d exp 133", lat); end
    tests++; if (data !== 7'd127 || ovr !== 1'b1) begin fails++; $display("FAIL ovr_result got %0d/%b exp 127/1", data, ovr); end
    xfer();
    repeat (3) @(negedge clk);
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL ovr_start_queued got %b exp 0", busy); end
  endtask

  task automatic test_tie;
    int lat, ra;
    thr = 127; comp_en = 1;
    launch(0, lat, ra);
    tests++; if (lat !== 133) begin fails++; $display("FAIL tie_latency got %0d exp 133", lat); end
    tests++; if (data !== 7'd127 || ovr !== 1'b0) begin fails++; $display("FAIL tie_result got %0d/%b exp 127/0", data, ovr); end
    xfer();
  endtask

  task automatic test_backpressure;
    int lat, ra;
    bit stable = 1;
    thr = 50; comp_en = 1;
    launch(0, lat, ra);
    tests++; if (lat !== 56) begin fails++; $display("FAIL bp_latency got %0d exp 56", lat); end
    for (int i = 0; i < 50; i++) begin
      if (valid !== 1'b1 || data !== 7'd50 || ovr !== 1'b0) stable = 0;
      @(negedge clk);
    end
    tests++; if (!stable) begin fails++; $display("FAIL bp_stable got unstable exp stable (last %b/%0d/%b)", valid, data, ovr); end
    xfer();
    tests++; if (valid !== 1'b0 || busy !== 1'b0) begin fails++; $display("FAIL bp_done got %b%b exp 00", valid, busy); end
    @(negedge clk);
    tests++; if (valid !== 1'b0) begin fails++; $display("FAIL bp_single_xfer got %b exp 0", valid); end
  endtask

  task automatic test_abort;
    int lat, ra;
    bit hit = 0;
    comp_en = 0;
    start = 1;
    @(negedge clk);
    start = 0;
    for (int i = 0; i < 100 && !hit; i++) begin
      if (cnt_rst_n && ext == 7'd10) hit = 1;
      else @(negedge clk);
    end
    tests++; if (!hit) begin fails++; $display("FAIL abort_reach got none exp code 10"); end
    abort = 1;
    @(negedge clk);
    abort = 0;
    tests++; if ({busy, valid, cnt_rst_n} !== 3'b0) begin fails++; $display("FAIL abort_ramp got %b exp 000", {busy, valid, cnt_rst_n}); end
    tests++; if (data !== 7'd50 || ovr !== 1'b0) begin fails++; $display("FAIL abort_keep got %0d/%b exp 50/0", data, ovr); end
    abort = 1; start = 1;
    @(negedge clk);
    abort = 0; start = 0;
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL abort_over_start got %b exp 0", busy); end
    thr = 20; comp_en = 1;
    launch(0, lat, ra);
    tests++; if (lat !== 26 || data !== 7'd20) begin fails++; $display("FAIL abort_restart got %0d/%0d exp 26/20", lat, data); end
    abort = 1;
    @(negedge clk);
    abort = 0;
    tests++; if (valid !== 1'b0 || busy !== 1'b0 || data !== 7'd20) begin fails++; $display("FAIL abort_hold got %b%b/%0d exp 00/20", valid, busy, data); end
  endtask

  task automatic test_back_to_back;
    int pos[4];
    int nv = 0;
    thr = 30; comp_en = 1;
    ready = 1; start = 1;
    @(negedge clk);
    start = 0;
    for (int i = 1; i <= 120; i++) begin
      if (valid) begin
        if (nv < 4) pos[nv] = i;
        nv++;
      end
      @(negedge clk);
    end
`ifdef ADC_CONT_EN
    tests++; if (nv !== 3) begin fails++; $display("FAIL cont_count got %0d exp 3", nv); end
    tests++; if (pos[0] !== 36 || pos[1] !== 72 || pos[2] !== 108) begin fails++; $display("FAIL cont_spacing got %0d,%0d,%0d exp 36,72,108", pos[0], pos[1], pos[2]); end
    tests++; if (data !== 7'd30 || busy !== 1'b1) begin fails++; $display("FAIL cont_running got %0d/%b exp 30/1", data, busy); end
    abort = 1;
    @(negedge clk);
    abort = 0;
    repeat (3) @(negedge clk);
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL cont_abort got %b exp 0", busy); end
`else
    tests++; if (nv !== 1 || pos[0] !== 36) begin fails++; $display("FAIL single_shot got %0d valids first %0d exp 1 at 36", nv, pos[0]); end
    tests++; if (busy !== 1'b0 || data !== 7'd30) begin fails++; $display("FAIL single_shot_idle got %b/%0d exp 0/30", busy, data); end
`endif
    ready = 0;
  endtask

  task automatic test_reset_mid;
    bit seen = 0;
    comp_en = 0;
    ready = 1;
    start = 1;
    @(negedge clk);
    start = 0;
    repeat (20) @(negedge clk);
    tests++; if (cnt_rst_n !== 1'b1) begin fails++; $display("FAIL rst_mid_ramp got %b exp 1", cnt_rst_n); end
    reset_n = 0;
    #1;
    tests++; if ({busy, valid, cnt_rst_n, ovr} !== 4'b0 || data !== 7'd0) begin fails++; $display("FAIL rst_mid_async got %b/%0d exp 0000/0", {busy, valid, cnt_rst_n, ovr}, data); end
    @(negedge clk);
    reset_n = 1;
    for (int i = 0; i < 200; i++) begin
      if (valid || busy) seen = 1;
      @(negedge clk);
    end
    tests++; if (seen) begin fails++; $display("FAIL rst_mid_quiet got activity exp none"); end
    ready = 0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_overrange();
    test_tie();
    test_backpressure();
    test_abort();
    test_back_to_back();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
